// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types and helpers for the sync_fifo block.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sync_fifo_pkg;

    // What an occupancy counter does in a given cycle.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_INC  = 2'b01,
        CNT_DEC  = 2'b10
    } cnt_op_e;

    // A simultaneous push and pop leaves the count unchanged.
    function automatic cnt_op_e cnt_op(input logic push, input logic pull);
        if (push && !pull) return CNT_INC;
        if (pull && !push) return CNT_DEC;
        return CNT_HOLD;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: 2^ADDR_WIDTH x DATA_WIDTH storage, synchronous write, asynchronous read.
// Latency: write visible to reads on the cycle after wr_en; read is combinational.
// Backpressure: none; the owner guarantees it never overwrites live entries.
// Ports: clk; wr_en/wr_addr/wr_dat write port; rd_addr/rd_dat read port.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // No reset on the array: contents are only meaningful behind the count.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock valid/ready FIFO with occupancy level and almost-full/almost-empty flags.
// Latency: write to out_valid 1 cycle; 2 cycles when SYNC_FIFO_OUTREG_EN is defined (registered output stage).
// Backpressure: in_ready falls when the RAM is full (state only); out_data held while out_valid && !out_ready.
// Ports: clk, rst (synchronous, active-high); in_data/in_valid/in_ready producer side;
//        out_data/out_valid/out_ready consumer side; level, almost_full, almost_empty status.
// Build option: define SYNC_FIFO_OUTREG_EN for the prefetching output register (capacity 2^ADDR_WIDTH+1).
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] RAM_FULL = CW'(1 << ADDR_WIDTH);

    logic                  rst_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
    logic [CW-1:0]         level_q, level_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  wr_en;
    logic                  ram_rd_en;
    logic                  pop;
    logic [DATA_WIDTH-1:0] ram_rd_dat;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_dat  (in_data),
        .rd_addr (rd_ptr_q),
        .rd_dat  (ram_rd_dat)
    );

    // rst_q keeps in_ready low for one cycle after reset releases, and the
    // ready path never depends on in_valid or out_ready.
    assign in_ready = !rst_q && (ram_cnt_q != RAM_FULL);
    assign wr_en    = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

`ifdef SYNC_FIFO_OUTREG_EN
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;

    // Prefetch the RAM head whenever the output stage is empty or being
    // drained, so back-to-back pops stream without bubbles.
    always_comb begin
        ram_rd_en = (!out_vld_q || pop) && (ram_cnt_q != '0);
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        if (ram_rd_en) begin
            out_vld_d = 1'b1;
            out_dat_d = ram_rd_dat;
        end else if (pop) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    // Level covers the RAM plus the output register.
    assign level_d   = ram_cnt_d + CW'(out_vld_d);
`else
    assign ram_rd_en = pop;
    assign out_valid = (ram_cnt_q != '0);
    // Gated so the port reads zero while nothing valid is presented.
    assign out_data  = out_valid ? ram_rd_dat : '0;
    assign level_d   = ram_cnt_d;
`endif

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (ram_rd_en) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        unique case (cnt_op(wr_en, ram_rd_en))
            CNT_INC: ram_cnt_d = ram_cnt_q + CW'(1);
            CNT_DEC: ram_cnt_d = ram_cnt_q - CW'(1);
            default: ram_cnt_d = ram_cnt_q;
        endcase
    end

    // Flags are registered from the next-cycle level so they move on the
    // same edge as the transfer that changes the level.
    always_comb begin
        afull_d  = (int'(level_d) >= AFULL_THRESH);
        aempty_d = (int'(level_d) <= AEMPTY_THRESH);
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            level_q   <= '0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            level_q   <= level_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
        end
    end

    assign level        = level_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized and directed checks of sync_fifo against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sync_fifo;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int AF = 3;
    localparam int AE = 1;
`ifdef SYNC_FIFO_OUTREG_EN
    localparam bit OREG = 1'b1;
    localparam int CAP  = 5;
    localparam int LAT  = 2;
`else
    localparam bit OREG = 1'b0;
    localparam int CAP  = 4;
    localparam int LAT  = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   level;
    logic          almost_full;
    logic          almost_empty;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .AFULL_THRESH  (AF),
        .AEMPTY_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    // Reference model: the FIFO contents as a queue, oldest first.
    // m_reg says whether the head currently sits in the output register.
    logic [DW-1:0] mq [$];
    bit            m_reg = 1'b0;
    bit            m_rst = 1'b0;

    function automatic int ram_n();
        return mq.size() - ((OREG && m_reg) ? 1 : 0);
    endfunction

    function automatic bit e_valid();
        return OREG ? m_reg : (mq.size() != 0);
    endfunction

    function automatic bit e_ready();
        return !m_rst && (ram_n() < (1 << AW));
    endfunction

    // Advance one clock: model decides transfers from the spec rules, then
    // inputs may change 1 time unit after the edge.
    task automatic tick();
        bit pull;
        bit push;
        int rn;
        pull = e_valid() && out_ready;
        push = in_valid && e_ready();
        rn   = ram_n();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_reg = 1'b0;
            m_rst = 1'b1;
        end else begin
            m_reg = ((!m_reg || pull) && rn > 0) || (m_reg && !pull);
            if (pull) void'(mq.pop_front());
            if (push) mq.push_back(in_data);
            m_rst = 1'b0;
        end
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && mq.size() != 0; i++) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick(); tick();
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        n_tests++; if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
            n_fail++; $display("FAIL reset_flags got af=%b ae=%b exp af=0 ae=1", almost_full, almost_empty); end
        rst = 1'b0;
        tick();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] vals [4];
        int idx;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = vals[i];
            tick();
        end
        in_valid = 1'b0;
        n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_level got=%0d exp=4", level); end
        n_tests++; if (in_ready !== OREG) begin n_fail++; $display("FAIL fill_in_ready got=%b exp=%b", in_ready, OREG); end
        n_tests++; if (almost_full !== 1'b1 || almost_empty !== 1'b0) begin
            n_fail++; $display("FAIL fill_flags got af=%b ae=%b exp af=1 ae=0", almost_full, almost_empty); end
        idx = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (out_valid === 1'b1) begin
                n_tests++;
                if (idx >= 4 || out_data !== vals[idx & 3]) begin
                    n_fail++; $display("FAIL drain_data idx=%0d got=%h exp=%h", idx, out_data, vals[idx & 3]);
                end
                idx++;
            end
            tick();
        end
        out_ready = 1'b0;
        n_tests++; if (idx != 4) begin n_fail++; $display("FAIL drain_count got=%0d exp=4", idx); end
        n_tests++; if (level !== 3'd0 || almost_empty !== 1'b1) begin
            n_fail++; $display("FAIL drain_level got level=%0d ae=%b exp level=0 ae=1", level, almost_empty); end
    endtask

    task automatic test_full_simul();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < CAP + 2; i++) begin
            in_data = 8'($urandom);
            tick();
        end
        n_tests++; if (level !== 3'(CAP)) begin n_fail++; $display("FAIL full_level got=%0d exp=%0d", level, CAP); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        n_tests++; if (out_data !== mq[0]) begin n_fail++; $display("FAIL full_head got=%h exp=%h", out_data, mq[0]); end
        out_ready = 1'b1;
        in_data   = 8'hEE;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_tests++; if (level !== 3'(CAP - 1)) begin n_fail++; $display("FAIL simul_level got=%0d exp=%0d", level, CAP - 1); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL simul_in_ready got=%b exp=1", in_ready); end
        drain();
    endtask

    task automatic test_stream();
        int sent, rcvd, first, gaps;
        bit push;
        sent = 0; rcvd = 0; first = -1; gaps = 0;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= 300 && rcvd < 100; cyc++) begin
            in_valid = (sent < 100);
            in_data  = 8'(sent);
            push = in_valid && e_ready();
            tick();
            if (push) sent++;
            if (out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                n_tests++;
                if (out_data !== 8'(rcvd)) begin
                    n_fail++; $display("FAIL stream_data n=%0d got=%h exp=%h", rcvd, out_data, 8'(rcvd));
                end
                rcvd++;
            end else if (first >= 0) begin
                gaps++;
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        n_tests++; if (first != LAT) begin n_fail++; $display("FAIL stream_latency got=%0d exp=%0d", first, LAT); end
        n_tests++; if (gaps != 0) begin n_fail++; $display("FAIL stream_gaps got=%0d exp=0", gaps); end
        n_tests++; if (rcvd != 100) begin n_fail++; $display("FAIL stream_count got=%0d exp=100", rcvd); end
        n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL stream_end_level got=%0d exp=0", level); end
    endtask

    task automatic test_backpressure();
        bit            stall;
        logic [DW-1:0] held;
        stall = 1'b0; held = '0;
        for (int c = 0; c < 400; c++) begin
            n_tests++; if (out_valid !== e_valid()) begin
                n_fail++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", c, out_valid, e_valid()); end
            if (e_valid()) begin
                n_tests++; if (out_data !== mq[0]) begin
                    n_fail++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, out_data, mq[0]); end
            end
            if (stall) begin
                n_tests++; if (out_valid !== 1'b1 || out_data !== held) begin
                    n_fail++; $display("FAIL bp_hold cyc=%0d got=%h/%b exp=%h/1", c, out_data, out_valid, held); end
            end
            n_tests++; if (level !== 3'(mq.size()) || in_ready !== e_ready()) begin
                n_fail++; $display("FAIL bp_level cyc=%0d got=%0d/%b exp=%0d/%b", c, level, in_ready, mq.size(), e_ready()); end
            n_tests++; if (almost_full !== (mq.size() >= AF) || almost_empty !== (mq.size() <= AE)) begin
                n_fail++; $display("FAIL bp_flags cyc=%0d got af=%b ae=%b size=%0d", c, almost_full, almost_empty, mq.size()); end
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            stall = (out_valid === 1'b1) && !out_ready;
            held  = out_data;
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hA0 + i);
            tick();
        end
        n_tests++; if (level !== 3'd3) begin n_fail++; $display("FAIL rmid_pre_level got=%0d exp=3", level); end
        rst = 1'b1;
        tick();
        n_tests++; if (level !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rmid_clear got level=%0d ov=%b exp 0/0", level, out_valid); end
        n_tests++; if (in_ready !== 1'b0 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin
            n_fail++; $display("FAIL rmid_status got rdy=%b ae=%b af=%b exp 0/1/0", in_ready, almost_empty, almost_full); end
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        n_tests++; if (in_ready !== 1'b1 || level !== 3'd0) begin
            n_fail++; $display("FAIL rmid_release got rdy=%b level=%0d exp 1/0", in_ready, level); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_simul();
        test_stream();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
